// File: rtl/udp_stack_pkg.sv
// Shared definitions for the UDP transmit path.
//   BEAT_BYTES  : bytes per 64-bit stream beat
//   KEEP_FULL   : tkeep value of a fully populated beat
//   pkt_state_e : packetizer state encoding
//   is_closer() : decides whether a beat being loaded ends its datagram
package udp_stack_pkg;

    localparam int unsigned BEAT_BYTES = 8;
    localparam logic [BEAT_BYTES-1:0] KEEP_FULL = 8'hFF;

    typedef enum logic [2:0] {
        StEmpty,
        StOpenEmpty,
        StHeld,
        StSend,
        StSendLast
    } pkt_state_e;

    // beats_before counts beats of this datagram emitted ahead of the one being loaded.
    function automatic logic is_closer(input logic                  last,
                                       input logic [BEAT_BYTES-1:0] keep,
                                       input logic [11:0]           beats_before,
                                       input logic [11:0]           last_idx);
        return last | (keep != KEEP_FULL) | (beats_before == last_idx);
    endfunction

endpackage

// File: rtl/udp_tx_packetizer.sv
// Segments a continuous user beat stream into bounded UDP datagrams for udp_stack_top.
// A one-beat hold register delays each beat until the block knows whether another beat
// follows, so tlast can be attached to the true final beat. Datagrams close on user
// tlast, a partial tkeep, MAX_BEATS beats, or TIMEOUT idle cycles with a beat held.
//
// Ports:
//   tx_axis_aclk / tx_axis_aresetn : clock, async active-low reset
//   udp_enable                     : destination reachable; gates opening a datagram
//   s_axis_*                       : user payload stream (slave)
//   udp_tx_axis_*                  : datagram stream to udp_stack_top (master)
//   dgram_count                    : datagrams emitted, wraps at 2^32
module udp_tx_packetizer
    import udp_stack_pkg::*;
#(
    parameter int unsigned MAX_BEATS = 183,
    parameter int unsigned TIMEOUT   = 1024
) (
    input  logic                      tx_axis_aclk,
    input  logic                      tx_axis_aresetn,
    input  logic                      udp_enable,
    input  logic [BEAT_BYTES*8-1:0]   s_axis_tdata,
    input  logic [BEAT_BYTES-1:0]     s_axis_tkeep,
    input  logic                      s_axis_tvalid,
    input  logic                      s_axis_tlast,
    output logic                      s_axis_tready,
    output logic [BEAT_BYTES*8-1:0]   udp_tx_axis_tdata,
    output logic [BEAT_BYTES-1:0]     udp_tx_axis_tkeep,
    output logic                      udp_tx_axis_tvalid,
    output logic                      udp_tx_axis_tlast,
    input  logic                      udp_tx_axis_tready,
    output logic [31:0]               dgram_count
);

    localparam logic [11:0] LAST_BEAT_IDX = 12'(MAX_BEATS - 1);
    localparam logic [15:0] IDLE_LIMIT    = 16'(TIMEOUT - 1);

    pkt_state_e                r_state;
    logic [BEAT_BYTES*8-1:0]   r_data;
    logic [BEAT_BYTES-1:0]     r_keep;
    logic                      r_valid;
    logic                      r_last;
    logic [11:0]               r_beat_cnt;
    logic [15:0]               r_idle_cnt;
    logic [31:0]               r_dgram_cnt;
    logic                      r_run;   // low during and just after reset so tready starts at 0

    logic                      w_ready;
    logic                      w_in_hs;
    logic                      w_out_hs;
    logic                      w_closer;
    logic [11:0]               w_beats_before;

    always_comb begin
        w_ready = 1'b0;
        case (r_state)
            StEmpty:     w_ready = udp_enable & r_run;
            StOpenEmpty: w_ready = 1'b1;
            StSend:      w_ready = udp_tx_axis_tready;
            default:     w_ready = 1'b0;
        endcase
    end

    assign s_axis_tready = w_ready;
    assign w_in_hs       = s_axis_tvalid & w_ready;
    assign w_out_hs      = r_valid & udp_tx_axis_tready;

    // In SEND the held beat leaves in the same cycle the new one loads, so count it too.
    assign w_beats_before = (r_state == StSend) ? r_beat_cnt + 12'd1 : r_beat_cnt;
    assign w_closer       = is_closer(s_axis_tlast, s_axis_tkeep, w_beats_before, LAST_BEAT_IDX);

    assign udp_tx_axis_tdata  = r_data;
    assign udp_tx_axis_tkeep  = r_keep;
    assign udp_tx_axis_tvalid = r_valid;
    assign udp_tx_axis_tlast  = r_last;
    assign dgram_count        = r_dgram_cnt;

    always_ff @(posedge tx_axis_aclk or negedge tx_axis_aresetn) begin
        if (!tx_axis_aresetn) begin
            r_state     <= StEmpty;
            r_data      <= '0;
            r_keep      <= '0;
            r_valid     <= 1'b0;
            r_last      <= 1'b0;
            r_beat_cnt  <= '0;
            r_idle_cnt  <= '0;
            r_dgram_cnt <= '0;
            r_run       <= 1'b0;
        end else begin
            r_run <= 1'b1;
            case (r_state)
                // OPEN_EMPTY is only reached if the user drops tvalid while the stack takes
                // the held beat in SEND; the datagram then waits open for the next beat.
                StEmpty, StOpenEmpty: begin
                    if (w_in_hs) begin
                        r_data <= s_axis_tdata;
                        r_keep <= s_axis_tkeep;
                        if (w_closer) begin
                            r_state <= StSendLast;
                            r_valid <= 1'b1;
                            r_last  <= 1'b1;
                        end else begin
                            r_state <= StHeld;
                        end
                    end
                end
                // A following beat wins over a timeout hitting in the same cycle.
                StHeld: begin
                    if (s_axis_tvalid) begin
                        r_state    <= StSend;
                        r_valid    <= 1'b1;
                        r_last     <= 1'b0;
                        r_idle_cnt <= '0;
                    end else if (r_idle_cnt == IDLE_LIMIT) begin
                        r_state    <= StSendLast;
                        r_valid    <= 1'b1;
                        r_last     <= 1'b1;
                        r_idle_cnt <= '0;
                    end else begin
                        r_idle_cnt <= r_idle_cnt + 16'd1;
                    end
                end
                StSend: begin
                    if (w_out_hs) begin
                        r_beat_cnt <= r_beat_cnt + 12'd1;
                        if (s_axis_tvalid) begin
                            r_data <= s_axis_tdata;
                            r_keep <= s_axis_tkeep;
                            if (w_closer) begin
                                r_state <= StSendLast;
                                r_last  <= 1'b1;
                            end else begin
                                r_state <= StHeld;
                                r_valid <= 1'b0;
                            end
                        end else begin
                            r_state <= StOpenEmpty;
                            r_valid <= 1'b0;
                        end
                    end
                end
                StSendLast: begin
                    if (w_out_hs) begin
                        r_state     <= StEmpty;
                        r_valid     <= 1'b0;
                        r_last      <= 1'b0;
                        r_beat_cnt  <= '0;
                        r_dgram_cnt <= r_dgram_cnt + 32'd1;
                    end
                end
                default: begin
                    r_state <= StEmpty;
                    r_valid <= 1'b0;
                    r_last  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_udp_tx_packetizer.sv
// Directed self-checking bench for udp_tx_packetizer with MAX_BEATS=4, TIMEOUT=8.
`timescale 1ns/1ps
module tb_udp_tx_packetizer;

    localparam int unsigned MAX_BEATS = 4;
    localparam int unsigned TIMEOUT   = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        udp_enable = 1'b1;
    logic [63:0] s_tdata = '0;
    logic [7:0]  s_tkeep = '0;
    logic        s_tvalid = 1'b0;
    logic        s_tlast = 1'b0;
    logic        s_tready;
    logic [63:0] u_tdata;
    logic [7:0]  u_tkeep;
    logic        u_tvalid;
    logic        u_tlast;
    logic        u_tready = 1'b1;
    logic [31:0] dgram_count;

    int checks = 0;
    int fails = 0;
    int cyc = 0;
    int last_acc_cyc = 0;
    bit tog = 1'b0;

    logic [63:0] q_data[$];
    logic [7:0]  q_keep[$];
    logic        q_last[$];
    int          q_cyc[$];

    udp_tx_packetizer #(
        .MAX_BEATS(MAX_BEATS),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .tx_axis_aclk      (clk),
        .tx_axis_aresetn   (rst_n),
        .udp_enable        (udp_enable),
        .s_axis_tdata      (s_tdata),
        .s_axis_tkeep      (s_tkeep),
        .s_axis_tvalid     (s_tvalid),
        .s_axis_tlast      (s_tlast),
        .s_axis_tready     (s_tready),
        .udp_tx_axis_tdata (u_tdata),
        .udp_tx_axis_tkeep (u_tkeep),
        .udp_tx_axis_tvalid(u_tvalid),
        .udp_tx_axis_tlast (u_tlast),
        .udp_tx_axis_tready(u_tready),
        .dgram_count       (dgram_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Handshakes are seen mid-cycle and complete on the following rising edge.
    always @(negedge clk) begin
        if (rst_n && u_tvalid && u_tready) begin
            q_data.push_back(u_tdata);
            q_keep.push_back(u_tkeep);
            q_last.push_back(u_tlast);
            q_cyc.push_back(cyc);
        end
        if (rst_n && s_tvalid && s_tready) last_acc_cyc = cyc;
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (tog) u_tready = ~u_tready;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [63:0] d, input logic [7:0] k, input logic l);
        int n = 0;
        s_tdata  = d;
        s_tkeep  = k;
        s_tlast  = l;
        s_tvalid = 1'b1;
        @(negedge clk);
        while (s_tready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (s_tready !== 1'b1) begin
            fails++;
            $display("FAIL push_accept: tready=%b after %0d cycles, required 1", s_tready, n);
        end
        tick();
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic wait_out(input int n);
        int k = 0;
        while (q_data.size() < n && k < 200) begin
            tick();
            k++;
        end
        checks++;
        if (q_data.size() < n) begin
            fails++;
            $display("FAIL wait_out: %0d beats seen, required %0d", q_data.size(), n);
        end
        tick();
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({u_tvalid, u_tlast, s_tready} !== 3'b000) begin
            fails++;
            $display("FAIL reset_ctrl: valid/last/tready=%b, required 000",
                     {u_tvalid, u_tlast, s_tready});
        end
        checks++;
        if ({u_tdata, u_tkeep} !== 72'h0) begin
            fails++;
            $display("FAIL reset_data: data=%h keep=%h, required 0", u_tdata, u_tkeep);
        end
        checks++;
        if (dgram_count !== 32'd0) begin
            fails++;
            $display("FAIL reset_count: dgram_count=%0d, required 0", dgram_count);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (s_tready !== 1'b1) begin
            fails++;
            $display("FAIL idle_tready: tready=%b, required 1", s_tready);
        end
    endtask

    // 10 full beats without tlast: datagrams of 4, 4, 2; the last one closes by timeout.
    task automatic test_stream10();
        int base = q_data.size();
        logic exp_last;
        for (int i = 1; i <= 10; i++) push(64'hA5A5_0000_0000_0000 | 64'(i), 8'hFF, 1'b0);
        wait_out(base + 10);
        for (int i = 0; i < 10; i++) begin
            exp_last = (i == 3) || (i == 7) || (i == 9);
            checks++;
            if (q_data.size() <= base + i) begin
                fails++;
                $display("FAIL stream_beat%0d: missing, required present", i);
            end else if (q_data[base+i] !== (64'hA5A5_0000_0000_0000 | 64'(i + 1)) ||
                         q_keep[base+i] !== 8'hFF || q_last[base+i] !== exp_last) begin
                fails++;
                $display("FAIL stream_beat%0d: data=%h keep=%h last=%b, required %h FF %b", i,
                         q_data[base+i], q_keep[base+i], q_last[base+i],
                         64'hA5A5_0000_0000_0000 | 64'(i + 1), exp_last);
            end
        end
        checks++;
        if (q_data.size() > base + 9 && q_cyc[base+9] - last_acc_cyc - 1 != int'(TIMEOUT)) begin
            fails++;
            $display("FAIL stream_timeout: idle gap=%0d cycles, required %0d",
                     q_cyc[base+9] - last_acc_cyc - 1, TIMEOUT);
        end
        checks++;
        if (dgram_count !== 32'd3) begin
            fails++;
            $display("FAIL stream_count: dgram_count=%0d, required 3", dgram_count);
        end
    endtask

    // Partial tkeep on the third beat closes the datagram immediately.
    task automatic test_partial_keep();
        int base = q_data.size();
        logic [7:0] exp_keep;
        push(64'h1111_0000_0000_0001, 8'hFF, 1'b0);
        push(64'h1111_0000_0000_0002, 8'hFF, 1'b0);
        push(64'h1111_0000_0000_0003, 8'h07, 1'b0);
        wait_out(base + 3);
        for (int i = 0; i < 3; i++) begin
            exp_keep = (i == 2) ? 8'h07 : 8'hFF;
            checks++;
            if (q_data.size() <= base + i) begin
                fails++;
                $display("FAIL partial_beat%0d: missing, required present", i);
            end else if (q_data[base+i] !== (64'h1111_0000_0000_0000 | 64'(i + 1)) ||
                         q_keep[base+i] !== exp_keep || q_last[base+i] !== (i == 2)) begin
                fails++;
                $display("FAIL partial_beat%0d: data=%h keep=%h last=%b, required keep %h last %b",
                         i, q_data[base+i], q_keep[base+i], q_last[base+i], exp_keep, i == 2);
            end
        end
        checks++;
        if (q_data.size() > base + 2 && q_cyc[base+2] - last_acc_cyc - 1 != 0) begin
            fails++;
            $display("FAIL partial_latency: idle gap=%0d cycles, required 0",
                     q_cyc[base+2] - last_acc_cyc - 1);
        end
        checks++;
        if (dgram_count !== 32'd4) begin
            fails++;
            $display("FAIL partial_count: dgram_count=%0d, required 4", dgram_count);
        end
    endtask

    task automatic test_enable_gate();
        int base = q_data.size();
        udp_enable = 1'b0;
        s_tdata    = 64'hC0DE_0000_0000_0001;
        s_tkeep    = 8'hFF;
        s_tlast    = 1'b1;
        s_tvalid   = 1'b1;
        repeat (4) begin
            @(negedge clk);
            checks++;
            if (s_tready !== 1'b0) begin
                fails++;
                $display("FAIL gate_tready: tready=%b with enable low, required 0", s_tready);
            end
        end
        checks++;
        if (q_data.size() != base || u_tvalid !== 1'b0) begin
            fails++;
            $display("FAIL gate_output: beats=%0d valid=%b, required %0d 0",
                     q_data.size(), u_tvalid, base);
        end
        tick();
        udp_enable = 1'b1;
        @(negedge clk);
        checks++;
        if (s_tready !== 1'b1) begin
            fails++;
            $display("FAIL gate_release: tready=%b after enable, required 1", s_tready);
        end
        tick();
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        wait_out(base + 1);
        checks++;
        if (q_data.size() <= base) begin
            fails++;
            $display("FAIL gate_beat: missing, required present");
        end else if (q_data[base] !== 64'hC0DE_0000_0000_0001 || q_last[base] !== 1'b1) begin
            fails++;
            $display("FAIL gate_beat: data=%h last=%b, required C0DE000000000001 1",
                     q_data[base], q_last[base]);
        end
        checks++;
        if (dgram_count !== 32'd5) begin
            fails++;
            $display("FAIL gate_count: dgram_count=%0d, required 5", dgram_count);
        end
    endtask

    // Enable drops mid-datagram: the datagram completes, then input stalls.
    task automatic test_enable_drop();
        int base = q_data.size();
        push(64'h2222_0000_0000_0001, 8'hFF, 1'b0);
        push(64'h2222_0000_0000_0002, 8'hFF, 1'b0);
        udp_enable = 1'b0;
        push(64'h2222_0000_0000_0003, 8'hFF, 1'b0);
        push(64'h2222_0000_0000_0004, 8'hFF, 1'b1);
        wait_out(base + 4);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (q_data.size() <= base + i) begin
                fails++;
                $display("FAIL drop_beat%0d: missing, required present", i);
            end else if (q_data[base+i] !== (64'h2222_0000_0000_0000 | 64'(i + 1)) ||
                         q_last[base+i] !== (i == 3)) begin
                fails++;
                $display("FAIL drop_beat%0d: data=%h last=%b, required last %b", i,
                         q_data[base+i], q_last[base+i], i == 3);
            end
        end
        checks++;
        if (dgram_count !== 32'd6) begin
            fails++;
            $display("FAIL drop_count: dgram_count=%0d, required 6", dgram_count);
        end
        s_tdata  = 64'h2222_0000_0000_0005;
        s_tvalid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (s_tready !== 1'b0) begin
                fails++;
                $display("FAIL drop_stall: tready=%b after close, required 0", s_tready);
            end
        end
        tick();
        s_tvalid   = 1'b0;
        udp_enable = 1'b1;
        checks++;
        if (q_data.size() != base + 4) begin
            fails++;
            $display("FAIL drop_extra: beats=%0d, required %0d", q_data.size(), base + 4);
        end
    endtask

    task automatic test_backpressure();
        int base = q_data.size();
        tog = 1'b1;
        for (int i = 1; i <= 4; i++) push(64'h3333_0000_0000_0000 | 64'(i), 8'hFF, i == 4);
        wait_out(base + 4);
        tog = 1'b0;
        tick();
        u_tready = 1'b1;
        tick();
        checks++;
        if (q_data.size() != base + 4) begin
            fails++;
            $display("FAIL bp_count_beats: beats=%0d, required %0d", q_data.size(), base + 4);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (q_data.size() <= base + i) begin
                fails++;
                $display("FAIL bp_beat%0d: missing, required present", i);
            end else if (q_data[base+i] !== (64'h3333_0000_0000_0000 | 64'(i + 1)) ||
                         q_last[base+i] !== (i == 3)) begin
                fails++;
                $display("FAIL bp_beat%0d: data=%h last=%b, required last %b", i,
                         q_data[base+i], q_last[base+i], i == 3);
            end
        end
        checks++;
        if (dgram_count !== 32'd7) begin
            fails++;
            $display("FAIL bp_count: dgram_count=%0d, required 7", dgram_count);
        end
    endtask

    task automatic test_reset_held();
        int base = q_data.size();
        push(64'hDEAD_0000_0000_0000, 8'hFF, 1'b0);
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({u_tvalid, u_tlast, s_tready} !== 3'b000 || {u_tdata, u_tkeep} !== 72'h0) begin
            fails++;
            $display("FAIL held_reset: valid/last/tready=%b data=%h keep=%h, required all 0",
                     {u_tvalid, u_tlast, s_tready}, u_tdata, u_tkeep);
        end
        checks++;
        if (dgram_count !== 32'd0) begin
            fails++;
            $display("FAIL held_reset_count: dgram_count=%0d, required 0", dgram_count);
        end
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        for (int i = 1; i <= 4; i++) push(64'h4444_0000_0000_0000 | 64'(i), 8'hFF, 1'b0);
        wait_out(base + 4);
        checks++;
        if (q_data.size() != base + 4) begin
            fails++;
            $display("FAIL held_beats: beats=%0d, required %0d", q_data.size(), base + 4);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (q_data.size() <= base + i) begin
                fails++;
                $display("FAIL held_beat%0d: missing, required present", i);
            end else if (q_data[base+i] !== (64'h4444_0000_0000_0000 | 64'(i + 1)) ||
                         q_last[base+i] !== (i == 3)) begin
                fails++;
                $display("FAIL held_beat%0d: data=%h last=%b, required last %b", i,
                         q_data[base+i], q_last[base+i], i == 3);
            end
        end
        checks++;
        if (dgram_count !== 32'd1) begin
            fails++;
            $display("FAIL held_count: dgram_count=%0d, required 1", dgram_count);
        end
    endtask

    initial begin
        test_reset();
        test_stream10();
        test_partial_keep();
        test_enable_gate();
        test_enable_drop();
        test_backpressure();
        test_reset_held();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
